// File: rtl/elevator_call_dispatcher.sv
// SCAN-policy floor-request dispatcher that feeds targets to the elevator car controller.
// Build option: define EMERGENCY_HOLD_EN to add the emergency_button input and a HALT state.
module elevator_call_dispatcher #(
  parameter int NUM_FLOORS    = 8,
  parameter int STROBE_CYCLES = 4,
  parameter int DWELL_CYCLES  = 16
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [NUM_FLOORS:1]   btn,
  input  logic [0:6]            seg_floor,
  input  logic [0:13]           door_code,
`ifdef EMERGENCY_HOLD_EN
  input  logic                  emergency_button,
`endif
  output logic [NUM_FLOORS:1]   input_floor,
  output logic                  in_floor,
  output logic [NUM_FLOORS:1]   pending,
  output logic [3:0]            cur_floor,
  output logic                  busy,
  output logic                  seg_error,
  output logic [2:0]            dbg_state_o
);

  // Handshake: input_floor is valid from the first ISSUE cycle until retire;
  // the controller captures it on the rising edge of in_floor. No ready exists.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    ISSUE  = 3'd2,
    TRAVEL = 3'd3,
    DWELL  = 3'd4
`ifdef EMERGENCY_HOLD_EN
    , HALT = 3'd5
`endif
  } state_e;

  localparam logic [0:13] DOOR_OPEN   = 14'b0011000_0000001;
  localparam logic [7:0]  STROBE_LAST = 8'(STROBE_CYCLES);
  localparam logic [7:0]  DWELL_LAST  = 8'(DWELL_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  dir_up_q, dir_up_d;
  logic [3:0]            target_q, target_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [NUM_FLOORS:1]   pending_q, pending_d;
  logic [3:0]            cur_floor_q, cur_floor_d;

  logic [3:0]            seg_num;
  logic                  seg_legal;
  logic                  door_open;
  logic [NUM_FLOORS:1]   target_oh;
  logic [3:0]            lo_ge, hi_lt, hi_le, lo_gt;
  logic                  lo_ge_vld, hi_lt_vld, hi_le_vld, lo_gt_vld;

  always_comb begin
    seg_num   = 4'd0;
    seg_legal = 1'b1;
    case (seg_floor)
      7'b0100001: seg_num = 4'd1;
      7'b1001111: seg_num = 4'd2;
      7'b0010010: seg_num = 4'd3;
      7'b0000110: seg_num = 4'd4;
      7'b1001100: seg_num = 4'd5;
      7'b0100100: seg_num = 4'd6;
      7'b0100000: seg_num = 4'd7;
      7'b0001111: seg_num = 4'd8;
      default:    seg_legal = 1'b0;
    endcase
    cur_floor_d = seg_legal ? seg_num : cur_floor_q;
  end

  assign door_open = (door_code == DOOR_OPEN);

  always_comb begin
    target_oh = '0;
    for (int f = 1; f <= NUM_FLOORS; f++)
      target_oh[f] = (int'(target_q) == f);
  end

  // Four sweep candidates around the current floor; descending loops leave the lowest hit.
  always_comb begin
    lo_ge = 4'd0; lo_ge_vld = 1'b0;
    lo_gt = 4'd0; lo_gt_vld = 1'b0;
    hi_le = 4'd0; hi_le_vld = 1'b0;
    hi_lt = 4'd0; hi_lt_vld = 1'b0;
    for (int f = NUM_FLOORS; f >= 1; f--) begin
      if (pending_q[f] && f >= int'(cur_floor_q)) begin
        lo_ge = 4'(f); lo_ge_vld = 1'b1;
      end
      if (pending_q[f] && f > int'(cur_floor_q)) begin
        lo_gt = 4'(f); lo_gt_vld = 1'b1;
      end
    end
    for (int f = 1; f <= NUM_FLOORS; f++) begin
      if (pending_q[f] && f <= int'(cur_floor_q)) begin
        hi_le = 4'(f); hi_le_vld = 1'b1;
      end
      if (pending_q[f] && f < int'(cur_floor_q)) begin
        hi_lt = 4'(f); hi_lt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_up_d  = dir_up_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    pending_d = pending_q | btn;
    case (state_q)
      IDLE: begin
        if (pending_q != '0) state_d = SELECT;
      end
      SELECT: begin
        cnt_d = '0;
        if (dir_up_q) begin
          if (lo_ge_vld) begin
            target_d = lo_ge;
            state_d  = ISSUE;
          end else if (hi_lt_vld) begin
            dir_up_d = 1'b0;
            target_d = hi_lt;
            state_d  = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (hi_le_vld) begin
            target_d = hi_le;
            state_d  = ISSUE;
          end else if (lo_gt_vld) begin
            dir_up_d = 1'b1;
            target_d = lo_gt;
            state_d  = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      ISSUE: begin
        // cnt 0 is the setup cycle; cnt 1..STROBE_CYCLES hold in_floor high.
        if (cnt_q == STROBE_LAST) begin
          state_d = TRAVEL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      TRAVEL: begin
        if (seg_legal && cur_floor_q == target_q && door_open) begin
          state_d = DWELL;
          cnt_d   = '0;
        end
      end
      DWELL: begin
        pending_d = pending_q | (btn & ~target_oh);
        if (!door_open) begin
          cnt_d = '0;
        end else if (cnt_q == DWELL_LAST) begin
          pending_d = pending_d & ~target_oh;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef EMERGENCY_HOLD_EN
      HALT: begin
        pending_d = '0;
        if (!emergency_button) begin
          state_d  = IDLE;
          dir_up_d = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef EMERGENCY_HOLD_EN
    if (emergency_button) begin
      state_d   = HALT;
      pending_d = '0;
      cnt_d     = '0;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q     <= IDLE;
      dir_up_q    <= 1'b1;
      target_q    <= 4'd0;
      cnt_q       <= '0;
      pending_q   <= '0;
      cur_floor_q <= 4'd1;
    end else begin
      state_q     <= state_d;
      dir_up_q    <= dir_up_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      cur_floor_q <= cur_floor_d;
    end
  end

  assign input_floor = (state_q == ISSUE || state_q == TRAVEL || state_q == DWELL) ? target_oh : '0;
  assign in_floor    = (state_q == ISSUE) && (cnt_q != 8'd0);
  assign pending     = pending_q;
  assign cur_floor   = cur_floor_q;
  assign busy        = (state_q != IDLE);
  assign seg_error   = !seg_legal;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// Scoreboard bench for elevator_call_dispatcher: a behavioural car/request model predicts
// each issued target, pending set and retire timing while the bench plays the car.
`timescale 1ns/1ps
module tb_elevator_call_dispatcher;
  localparam int STROBE = 4;
  localparam int DWELL  = 16;
  localparam logic [0:13] D_OPEN   = 14'b0011000_0000001;
  localparam logic [0:13] D_CLOSED = 14'b1110001_0110001;
  localparam logic [0:6]  SEG_BAD  = 7'b1111111;

  logic       CLK = 1'b0;
  logic       reset;
  logic [8:1] btn;
  logic [0:6] seg_floor;
  logic [0:13] door_code;
  logic [8:1] input_floor, pending;
  logic       in_floor, busy, seg_error;
  logic [3:0] cur_floor;
  logic [2:0] dbg_state;
`ifdef EMERGENCY_HOLD_EN
  logic       emergency_button = 1'b0;
`endif

  elevator_call_dispatcher dut (
    .CLK(CLK), .reset(reset), .btn(btn), .seg_floor(seg_floor), .door_code(door_code),
`ifdef EMERGENCY_HOLD_EN
    .emergency_button(emergency_button),
`endif
    .input_floor(input_floor), .in_floor(in_floor), .pending(pending),
    .cur_floor(cur_floor), .busy(busy), .seg_error(seg_error), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  bit mon_prev = 1'b0;
  int mon_run = 0;
  bit skip_run = 1'b0;

  // car / request model
  logic [8:1] m_pend;
  int m_cur;
  bit m_up;
  int m_tgt;

  function automatic logic [0:6] seg_code(input int f);
    case (f)
      1: return 7'b0100001;
      2: return 7'b1001111;
      3: return 7'b0010010;
      4: return 7'b0000110;
      5: return 7'b1001100;
      6: return 7'b0100100;
      7: return 7'b0100000;
      8: return 7'b0001111;
      default: return SEG_BAD;
    endcase
  endfunction

  function automatic logic [7:0] onehot(input int f);
    logic [7:0] v;
    v = '0;
    v[f-1] = 1'b1;
    return v;
  endfunction

  // Sweep rule: keep going the current way if anything lies ahead (own floor included), else turn.
  function automatic void scan(input logic [8:1] p, input int cur, input bit up,
                               output int tgt, output bit up_o);
    tgt = 0;
    up_o = up;
    if (up) begin
      for (int f = cur; f <= 8; f++) if (p[f] && tgt == 0) tgt = f;
      if (tgt == 0) begin
        up_o = 1'b0;
        for (int f = cur - 1; f >= 1; f--) if (p[f] && tgt == 0) tgt = f;
      end
    end else begin
      for (int f = cur; f >= 1; f--) if (p[f] && tgt == 0) tgt = f;
      if (tgt == 0) begin
        up_o = 1'b1;
        for (int f = cur + 1; f <= 8; f++) if (p[f] && tgt == 0) tgt = f;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (in_floor && !mon_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL issue_unexpected: got input_floor %0h expected no issue", input_floor);
      end else begin
        check("issue_target", input_floor, exp_q.pop_front());
      end
    end
    if (in_floor) mon_run++;
    if (!in_floor && mon_prev) begin
      if (!skip_run) check("strobe_len", mon_run, STROBE);
      mon_run = 0;
    end
    mon_prev = in_floor;
  end

  // ---------------- driver tasks ----------------
  task automatic plan_next();
    bit up_n;
    if (m_pend != '0) begin
      scan(m_pend, m_cur, m_up, m_tgt, up_n);
      m_up = up_n;
      exp_q.push_back(onehot(m_tgt));
    end
  endtask

  task automatic idle_press(input logic [8:1] p);
    btn = p;
    m_pend |= p;
    plan_next();
    @(negedge CLK);
    btn = '0;
  endtask

  task automatic wait_strobe_done();
    bit seen = 1'b0;
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      if (in_floor) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    check("strobe_complete", done, 1'b1);
  endtask

  task automatic serve(input bit glitch, input bit reclose,
                       input logic [8:1] tpress, input logic [8:1] dpress);
    int t;
    int n_open;
    logic [2:0] st0;
    t = m_tgt;
    wait_strobe_done();
    btn = tpress;
    m_pend |= tpress;
    @(negedge CLK);
    btn = '0;
    while (m_cur != t) begin
      m_cur += (t > m_cur) ? 1 : -1;
      seg_floor = seg_code(m_cur);
      repeat (2) @(negedge CLK);
    end
    if (glitch) begin
      seg_floor = SEG_BAD;
      door_code = D_OPEN;
      st0 = dbg_state;
      repeat (4) begin
        @(negedge CLK);
        check("seg_error", seg_error, 1'b1);
        check("cur_floor_hold", cur_floor, t);
        check("glitch_no_advance", dbg_state, st0);
      end
      seg_floor = seg_code(t);
    end
    door_code = D_OPEN;
    n_open = DWELL + 1;
    if (reclose) begin
      repeat (10) @(negedge CLK);
      door_code = D_CLOSED;
      @(negedge CLK);
      door_code = D_OPEN;
      n_open = DWELL;
    end
    m_pend |= dpress;
    for (int i = 1; i < n_open; i++) begin
      btn = (i >= 2 && i <= 8) ? dpress : 8'h00;
      @(negedge CLK);
    end
    btn = '0;
    check("seg_error_clear", seg_error, 1'b0);
    check("pre_retire_target", input_floor, onehot(t));
    check("pre_retire_pending", pending, m_pend);
    @(negedge CLK);
    door_code = D_CLOSED;
    m_pend[t] = 1'b0;
    check("retire_input_floor", input_floor, 8'h00);
    check("retire_busy", busy, 1'b0);
    check("retire_pending", pending, m_pend);
    check("retire_cur_floor", cur_floor, t);
    plan_next();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [8:1] p, tp, dp;
    reset = 1'b0;
    btn = '0;
    seg_floor = seg_code(1);
    door_code = D_CLOSED;
    m_pend = '0;
    m_cur = 1;
    m_up = 1'b1;
    m_tgt = 0;
    repeat (2) @(negedge CLK);
    check("reset_input_floor", input_floor, 8'h00);
    check("reset_in_floor", in_floor, 1'b0);
    check("reset_pending", pending, 8'h00);
    check("reset_cur_floor", cur_floor, 4'd1);
    check("reset_busy", busy, 1'b0);
    check("reset_seg_error", seg_error, 1'b0);
    reset = 1'b1;
    @(negedge CLK);

    // press floor 5, then check strobe latency against the press edge
    idle_press(8'h10);
    check("press_pending", pending, 8'h10);
    repeat (2) @(negedge CLK);
    check("setup_in_floor", in_floor, 1'b0);
    check("setup_input_floor", input_floor, 8'h10);
    @(negedge CLK);
    check("strobe_start", in_floor, 1'b1);
    serve(1'b0, 1'b0, 8'h00, 8'h00);

    // walk to floor 3 heading up, then pending {2,6}
    idle_press(8'h02);
    serve(1'b0, 1'b0, 8'h00, 8'h00);
    idle_press(8'h04);
    serve(1'b0, 1'b0, 8'h00, 8'h00);
    idle_press(8'h22);
    serve(1'b0, 1'b0, 8'h00, 8'h00);
    serve(1'b0, 1'b0, 8'h00, 8'h00);

    // door reclose restarts dwell at floor 4
    idle_press(8'h08);
    serve(1'b0, 1'b1, 8'h00, 8'h00);
    // illegal segment code while door is open at the target
    idle_press(8'h40);
    serve(1'b1, 1'b0, 8'h00, 8'h00);
    // btn[4] held at the served floor plus btn[7] during dwell
    idle_press(8'h08);
    serve(1'b0, 1'b0, 8'h00, 8'h48);
    serve(1'b0, 1'b0, 8'h00, 8'h00);

    for (int r = 0; r < 30; r++) begin
      if (m_pend == '0) begin
        p = 8'($urandom_range(1, 255));
        idle_press(p);
      end
      tp = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255) & $urandom_range(0, 255)) : 8'h00;
      dp = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255) & $urandom_range(0, 255)) : 8'h00;
      serve($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, tp, dp);
    end
    while (m_pend != '0) serve(1'b0, 1'b0, 8'h00, 8'h00);

    // reset in the middle of a strobe
    idle_press(8'h80);
    repeat (4) @(negedge CLK);
    check("pre_reset_strobe", in_floor, 1'b1);
    skip_run = 1'b1;
    reset = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    m_pend = '0;
    m_up = 1'b1;
    check("midreset_in_floor", in_floor, 1'b0);
    check("midreset_input_floor", input_floor, 8'h00);
    check("midreset_pending", pending, 8'h00);
    check("midreset_busy", busy, 1'b0);
    check("midreset_cur_floor", cur_floor, 4'd1);
    repeat (2) @(negedge CLK);
    skip_run = 1'b0;
    check("post_reset_cur_floor", cur_floor, m_cur);

`ifdef EMERGENCY_HOLD_EN
    idle_press(8'h01);
    repeat (4) @(negedge CLK);
    check("pre_halt_strobe", in_floor, 1'b1);
    skip_run = 1'b1;
    emergency_button = 1'b1;
    @(negedge CLK);
    check("halt_in_floor", in_floor, 1'b0);
    check("halt_input_floor", input_floor, 8'h00);
    check("halt_pending", pending, 8'h00);
    check("halt_busy", busy, 1'b1);
    btn = 8'hff;
    @(negedge CLK);
    btn = '0;
    emergency_button = 1'b0;
    check("halt_btn_ignored", pending, 8'h00);
    @(negedge CLK);
    m_pend = '0;
    m_up = 1'b1;
    check("halt_release_busy", busy, 1'b0);
    skip_run = 1'b0;
`endif

    repeat (5) @(negedge CLK);
    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
